// File: rtl/loop_fission_pkg.sv
// rtl/loop_fission_pkg.sv - shared widths, FSM states and default score bytes
package loop_fission_pkg;
  localparam int LANES = 16;
  localparam int AW    = 12;
  localparam int VW    = 8 * LANES;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [7:0] M1  = 8'h04;
  localparam logic [7:0] MCH = 8'h02;
  localparam logic [7:0] MIS = 8'hFC;
  localparam logic [7:0] NSC = 8'hFF;
endpackage

// File: rtl/ksw_score_vec.sv
// rtl/ksw_score_vec.sv - combinational per-lane substitution scorer
module ksw_score_vec
  import loop_fission_pkg::*;
(
  input  logic [VW-1:0] sf,
  input  logic [VW-1:0] qr,
  input  logic [VW-1:0] m1,
  input  logic [VW-1:0] mch,
  input  logic [VW-1:0] mis,
  input  logic [VW-1:0] nsc,
  output logic [VW-1:0] score
);
  always_comb begin
    score = '0;
    for (int i = 0; i < LANES; i++) begin
      // ambiguous base on either side overrides the match test
      if (sf[8*i +: 8] == m1[8*i +: 8] || qr[8*i +: 8] == m1[8*i +: 8])
        score[8*i +: 8] = nsc[8*i +: 8];
      else if (sf[8*i +: 8] == qr[8*i +: 8])
        score[8*i +: 8] = mch[8*i +: 8];
      else
        score[8*i +: 8] = mis[8*i +: 8];
    end
  end
endmodule

// File: rtl/loop_fission.sv
// rtl/loop_fission.sv - one anti-diagonal sweep: read 16-byte vectors, score, write back
module loop_fission
  import loop_fission_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] r,
  input  logic [AW-1:0] st0,
  input  logic [AW-1:0] en0,
  input  logic [AW-1:0] qlen,
  input  logic [VW-1:0] m1_,
  input  logic [VW-1:0] sc_mch_,
  input  logic [VW-1:0] sc_mis_,
  input  logic [VW-1:0] sc_N_,
  output logic          rd_en,
  output logic [AW-1:0] sf_addr,
  output logic [AW-1:0] qr_addr,
  input  logic [VW-1:0] sf_data,
  input  logic [VW-1:0] qr_data,
  output logic          s_we,
  output logic [AW-1:0] s_addr,
  output logic [VW-1:0] s_data,
  output logic          busy,
  output logic          done
);
  state_t        state;
  logic [AW-1:0] t, r_q, en0_q, qlen_q;
  logic [VW-1:0] m1_q, mch_q, mis_q, n_q;
  logic          last0, vld1, last1;
  logic [AW-1:0] addr1;
  logic [AW-1:0] cur_t, cur_r, cur_en, cur_qlen;
  logic [AW:0]   t_nx;
  logic          fin, issue;
  logic [VW-1:0] score;

  // the accepting cycle issues the first read straight from the input ports
  always_comb begin
    cur_t    = t;
    cur_r    = r_q;
    cur_en   = en0_q;
    cur_qlen = qlen_q;
    if (state == IDLE) begin
      cur_t    = st0;
      cur_r    = r;
      cur_en   = en0;
      cur_qlen = qlen;
    end
    t_nx  = {1'b0, cur_t} + (AW+1)'(LANES);
    fin   = t_nx > {1'b0, cur_en};
    issue = (state == RUN) || (state == IDLE && start && !(st0 > en0));
  end

  ksw_score_vec u_score (
    .sf    (sf_data),
    .qr    (qr_data),
    .m1    (m1_q),
    .mch   (mch_q),
    .mis   (mis_q),
    .nsc   (n_q),
    .score (score)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      t       <= '0;
      r_q     <= '0;
      en0_q   <= '0;
      qlen_q  <= '0;
      m1_q    <= '0;
      mch_q   <= '0;
      mis_q   <= '0;
      n_q     <= '0;
      rd_en   <= 1'b0;
      sf_addr <= '0;
      qr_addr <= '0;
      last0   <= 1'b0;
      vld1    <= 1'b0;
      last1   <= 1'b0;
      addr1   <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_data  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      vld1  <= rd_en;
      last1 <= last0;
      addr1 <= sf_addr;
      s_we  <= vld1;
      done  <= 1'b0;
      if (vld1) begin
        s_addr <= addr1;
        s_data <= score;
      end

      if (issue) begin
        rd_en   <= 1'b1;
        sf_addr <= cur_t;
        qr_addr <= cur_t + cur_qlen - AW'(1) - cur_r;
        t       <= t_nx[AW-1:0];
        last0   <= fin;
        state   <= fin ? DRAIN : RUN;
      end else begin
        rd_en <= 1'b0;
        last0 <= 1'b0;
      end

      case (state)
        IDLE: if (start) begin
          r_q    <= r;
          en0_q  <= en0;
          qlen_q <= qlen;
          m1_q   <= m1_;
          mch_q  <= sc_mch_;
          mis_q  <= sc_mis_;
          n_q    <= sc_N_;
          if (st0 > en0) done <= 1'b1;
          else           busy <= 1'b1;
        end
        DRAIN: if (vld1 && last1) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_loop_fission.sv
// tb/tb_loop_fission.sv - table-driven sweeps with a read/write scoreboard
module tb_loop_fission;
  import loop_fission_pkg::*;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [AW-1:0] r = '0, st0 = '0, en0 = '0, qlen = '0;
  logic [VW-1:0] m1_, sc_mch_, sc_mis_, sc_N_;
  logic          rd_en, s_we, busy, done;
  logic [AW-1:0] sf_addr, qr_addr, s_addr;
  logic [VW-1:0] sf_data = '0, qr_data = '0, s_data;

  loop_fission dut (
    .clk(clk), .rst_n(rst_n), .start(start), .r(r), .st0(st0), .en0(en0), .qlen(qlen),
    .m1_(m1_), .sc_mch_(sc_mch_), .sc_mis_(sc_mis_), .sc_N_(sc_N_),
    .rd_en(rd_en), .sf_addr(sf_addr), .qr_addr(qr_addr), .sf_data(sf_data), .qr_data(qr_data),
    .s_we(s_we), .s_addr(s_addr), .s_data(s_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] sf_mem [4096];
  logic [7:0] qr_mem [4096];

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [VW-1:0] d;
  } exp_t;
  exp_t rdq[$];
  exp_t wq[$];

  typedef struct {
    int st; int en; int rr; int ql; int nw;
  } vec_t;

  int tests = 0, fails = 0, cyc = 0, n_writes = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  bit exp_empty = 1'b0;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event occurred, none expected", nm);
  endtask

  function automatic logic [VW-1:0] sf_vec(input logic [AW-1:0] a);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[8*i +: 8] = sf_mem[AW'(a + AW'(i))];
    return v;
  endfunction

  function automatic logic [VW-1:0] qr_vec(input logic [AW-1:0] a);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[8*i +: 8] = qr_mem[AW'(a + AW'(i))];
    return v;
  endfunction

  function automatic logic [VW-1:0] model_score(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] o;
    for (int i = 0; i < LANES; i++) begin
      if (a[8*i +: 8] == m1_[8*i +: 8] || b[8*i +: 8] == m1_[8*i +: 8]) o[8*i +: 8] = sc_N_[8*i +: 8];
      else if (a[8*i +: 8] == b[8*i +: 8])                               o[8*i +: 8] = sc_mch_[8*i +: 8];
      else                                                                o[8*i +: 8] = sc_mis_[8*i +: 8];
    end
    return o;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      sf_data <= sf_vec(sf_addr);
      qr_data <= qr_vec(qr_addr);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rd_en) begin
      rd_cnt++;
      if (rdq.size() == 0) fail_now("extra_read");
      else begin
        e = rdq.pop_front();
        chk("sf_addr", sf_addr, e.a);
        chk("qr_addr", qr_addr, e.b);
      end
    end
    if (s_we) begin
      n_writes++;
      if (wq.size() == 0) fail_now("extra_write");
      else begin
        e = wq.pop_front();
        chk("s_addr", s_addr, e.a);
        chk("s_data", s_data, e.d);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_with_we", s_we, !exp_empty);
    end
  end

  task automatic set_defaults();
    m1_ = {LANES{M1}}; sc_mch_ = {LANES{MCH}}; sc_mis_ = {LANES{MIS}}; sc_N_ = {LANES{NSC}};
  endtask

  task automatic push_sweep(input int s, input int e, input int rr, input int ql);
    exp_t x;
    exp_empty = (s > e);
    for (int t = s; t <= e; t += 16) begin
      x.a = AW'(t);
      x.b = AW'(t + ql - 1 - rr);
      x.d = '0;
      rdq.push_back(x);
      x.d = model_score(sf_vec(x.a), qr_vec(x.b));
      wq.push_back(x);
    end
  endtask

  task automatic drive_start(input int s, input int e, input int rr, input int ql);
    st0 = AW'(s); en0 = AW'(e); r = AW'(rr); qlen = AW'(ql);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int k;
    for (k = 0; k < limit && done_cnt < target; k++) begin
      @(posedge clk); #1;
    end
    if (done_cnt < target) fail_now("done_timeout");
  endtask

  vec_t vt[$];
  logic [VW-1:0] exp_single;
  int w0, d0, k;

  initial begin
    set_defaults();
    for (int i = 0; i < 4096; i++) begin
      sf_mem[i] = 8'($urandom_range(0, 4));
      qr_mem[i] = 8'($urandom_range(0, 4));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {rd_en, s_we, done, busy}, 4'b0);
    chk("reset_addr", {sf_addr, qr_addr, s_addr}, '0);
    chk("reset_sdata", s_data, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single vector with hand-derived lane scores
    for (int i = 0; i < 16; i++) begin sf_mem[i] = 8'h02; qr_mem[i] = 8'h02; end
    sf_mem[1] = 8'h01; sf_mem[2] = 8'h04; sf_mem[3] = 8'h03; sf_mem[0] = 8'h00;
    qr_mem[1] = 8'h02; qr_mem[2] = 8'h01; qr_mem[3] = 8'h04; qr_mem[0] = 8'h00;
    exp_single = {LANES{8'h02}};
    exp_single[15:8] = 8'hFC; exp_single[23:16] = 8'hFF; exp_single[31:24] = 8'hFF;
    rdq.push_back('{a: 12'h000, b: 12'h000, d: '0});
    wq.push_back('{a: 12'h000, b: 12'h000, d: exp_single});
    exp_empty = 1'b0;
    w0 = n_writes; d0 = done_cnt;
    drive_start(0, 0, 0, 1);
    wait_done(d0 + 1, 50);
    chk("single_writes", n_writes - w0, 1);
    chk("single_latency", done_cyc - start_cyc, 4);

    vt.push_back('{st: 0,    en: 47,   rr: 5, ql: 100, nw: 3});
    vt.push_back('{st: 0,    en: 0,    rr: 1, ql: 0,   nw: 1});
    vt.push_back('{st: 32,   en: 16,   rr: 0, ql: 10,  nw: 0});
    vt.push_back('{st: 5,    en: 20,   rr: 3, ql: 50,  nw: 1});
    vt.push_back('{st: 5,    en: 21,   rr: 3, ql: 50,  nw: 2});
    vt.push_back('{st: 100,  en: 355,  rr: 0, ql: 300, nw: 16});
    vt.push_back('{st: 4080, en: 4095, rr: 7, ql: 20,  nw: 1});
    vt.push_back('{st: 4000, en: 4095, rr: 0, ql: 0,   nw: 6});
    vt.push_back('{st: 4095, en: 4095, rr: 2, ql: 9,   nw: 1});

    foreach (vt[i]) begin
      set_defaults();
      push_sweep(vt[i].st, vt[i].en, vt[i].rr, vt[i].ql);
      w0 = n_writes; d0 = done_cnt;
      drive_start(vt[i].st, vt[i].en, vt[i].rr, vt[i].ql);
      chk("busy_during", busy, vt[i].nw != 0);
      m1_ = {LANES{8'h02}}; sc_mch_ = VW'($urandom); sc_N_ = VW'($urandom);
      wait_done(d0 + 1, 400);
      chk("writes", n_writes - w0, vt[i].nw);
      chk("done_latency", done_cyc - start_cyc, (vt[i].nw == 0) ? 2 : vt[i].nw + 3);
      chk("busy_after", busy, 0);
      chk("queues_drained", rdq.size() + wq.size(), 0);
    end
    set_defaults();

    // start while busy is ignored
    push_sweep(0, 63, 2, 70);
    w0 = n_writes; d0 = done_cnt;
    drive_start(0, 63, 2, 70);
    @(posedge clk); #1;
    drive_start(0, 255, 0, 0);
    wait_done(d0 + 1, 100);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_start_writes", n_writes - w0, 4);
    chk("busy_start_dones", done_cnt - d0, 1);

    // back-to-back start in the done cycle
    push_sweep(16, 50, 1, 40);
    w0 = n_writes; d0 = done_cnt;
    drive_start(16, 50, 1, 40);
    for (k = 0; k < 100 && !done; k++) begin @(posedge clk); #1; end
    chk("b2b_first_done", done, 1);
    push_sweep(200, 231, 9, 10);
    drive_start(200, 231, 9, 10);
    wait_done(d0 + 2, 100);
    chk("b2b_writes", n_writes - w0, 5);
    chk("b2b_latency", done_cyc - start_cyc, 5);

    // reset mid-sweep
    push_sweep(0, 255, 0, 10);
    w0 = rd_cnt;
    drive_start(0, 255, 0, 10);
    for (k = 0; k < 50 && rd_cnt < w0 + 3; k++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ctrl", {rd_en, s_we, done, busy}, 4'b0);
    chk("midrst_addr", {sf_addr, qr_addr, s_addr}, '0);
    chk("midrst_sdata", s_data, '0);
    rdq.delete(); wq.delete();
    w0 = n_writes; d0 = done_cnt;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_we", n_writes - w0, 0);
    chk("midrst_no_done", done_cnt - d0, 0);

    push_sweep(0, 47, 5, 100);
    w0 = n_writes; d0 = done_cnt;
    drive_start(0, 47, 5, 100);
    wait_done(d0 + 1, 100);
    chk("post_rst_writes", n_writes - w0, 3);
    chk("post_rst_latency", done_cyc - start_cyc, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
